onehot_sweep_decoder: RTL
=========================

Name: onehot_sweep_decoder

Overview:
Parametrised, registered IDX_W-to-2^IDX_W one-hot decoder for cache set/line selection, with a sequential sweep mode. Single decode requests produce one registered one-hot word. A sweep walks an inclusive index range, possibly wrapping, and emits one one-hot word per cycle for flush and invalidate of tag/valid arrays. It sits between the cache controller and the per-line enable fan-out.

Parameters:
IDX_W, 7, index width; output width OUT_W = 2**IDX_W is derived and is not overridable.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
dec_en  input  1  single-decode request, accepted only when ready=1
id_in  input  IDX_W  index for single decode
sweep_start  input  1  sweep request, accepted only when ready=1
sweep_first  input  IDX_W  first sweep index, captured on acceptance
sweep_last  input  IDX_W  last sweep index (inclusive), captured on acceptance
ready  output  1  block can accept dec_en/sweep_start this cycle
one_hot_out  output  OUT_W  registered one-hot word; all-zero when out_valid=0
idx_out  output  IDX_W  binary index matching one_hot_out
out_valid  output  1  one_hot_out/idx_out valid this cycle
busy  output  1  pending or sweeping
sweep_done  output  1  one-cycle pulse coincident with the last sweep output

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; one_hot_out=0, idx_out=0, out_valid=0, busy=0, sweep_done=0; ready=1 from the first cycle after reset.
- Reset mid-sweep or in PEND aborts immediately with the reset values above; no sweep_done pulse.
- States: IDLE, PEND, SWEEP. ready = (state==IDLE); busy = (state!=IDLE).
- IDLE, dec_en only at edge T: at T+1 out_valid=1, one_hot_out bit id_in set (all other bits 0), idx_out=id_in. Back-to-back requests give one output per cycle. Latency is exactly 1.
- IDLE, sweep_start only at T:
  - Capture first/last; count N = ((last - first) mod OUT_W) + 1, range 1..OUT_W.
  - Enter SWEEP; outputs at T+1..T+N carry indices first, first+1, ... with IDX_W-bit modular wrap.
  - sweep_done=1 at T+N only; state=IDLE at T+N+1, so ready=1 in cycle T+N+1.
- first==last gives a single output with sweep_done in the same cycle.
- last<first wraps through OUT_W-1 to 0. Example, IDX_W=3, first=6, last=1: indices 6,7,0,1.
- The full range (last == first-1 mod OUT_W) gives OUT_W outputs.
- IDLE, dec_en and sweep_start both at T:
  - The decode output appears at T+1 while state=PEND.
  - Sweep outputs begin at T+2 (first) and end at T+N+1 with sweep_done.
  - Sweep bounds are captured at T.
- dec_en or sweep_start while ready=0 is ignored and has no side effects; the controller must hold the request.
- out_valid is 0 in PEND only if no decode was issued; PEND is entered only from a simultaneous request, so out_valid=1 in PEND.
- Invariant: out_valid=1 implies exactly one bit of one_hot_out is set, and that bit is idx_out.
- Sweep counter is IDX_W bits with natural wrap. The remaining-count register is IDX_W+1 bits so that N=OUT_W is representable.

Decomposition:
- Shared cache package holds:
  - the state enum (IDLE, PEND, SWEEP);
  - the default CACHE_IDX_W=7 (128 lines);
  - the word-select width 3.
- One combinational sub-module, onehot_dec_n (parameter IDX_W), performs the pure binary-to-one-hot conversion. It replaces the fixed-width decoders and feeds the output register.

Test Plan:
- Reset then dec_en=1, id_in=0x05 (IDX_W=7) -> next cycle out_valid=1, one_hot_out=1<<5 (0x20), idx_out=5, ready=1; following cycle out_valid=0, one_hot_out=0.
- IDX_W=3, sweep_first=2, sweep_last=5 -> outputs 0x04,0x08,0x10,0x20 on 4 consecutive cycles; sweep_done with 0x20; busy high for 4 cycles; ready high the cycle after.
- IDX_W=3, wrap sweep first=6, last=1 -> 0x40,0x80,0x01,0x02; then full range first=0, last=7 -> 8 outputs 0x01..0x80, sweep_done on 0x80.
- Simultaneous dec_en (id_in=3) and sweep_start (first=last=0), IDX_W=3 -> T+1 output 0x08 with busy=1; T+2 output 0x01 with sweep_done=1; ready=1 at T+3.
- dec_en=1 with id_in=7 pulsed during an active sweep -> ignored; sweep sequence unchanged; no 0x80 output outside the sweep order.
- rst asserted on the third cycle of a 128-line sweep (IDX_W=7, 0..127) -> next cycle all outputs 0, no sweep_done, ready=1; a new dec_en is then accepted normally.

Source files
------------

// File: rtl/onehot_sweep_decoder_pkg.sv
// ============================================================================
// onehot_sweep_decoder_pkg : shared cache-index constants and controller states
// Revision: 1.0
// ============================================================================
`default_nettype none

package onehot_sweep_decoder_pkg;

    localparam int CACHE_IDX_W = 7;   // 128 cache lines
    localparam int WORD_SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/onehot_dec_n.sv
// ============================================================================
// onehot_dec_n : combinational binary-to-one-hot converter, gated by en_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_dec_n
    import onehot_sweep_decoder_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W
) (
    input  logic [IDX_W-1:0]      idx_i,
    input  logic                  en_i,
    output logic [2**IDX_W-1:0]   onehot_o
);

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_bit
        assign onehot_o[i] = en_i && (idx_i == IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/onehot_sweep_decoder.sv
// ============================================================================
// onehot_sweep_decoder : registered one-hot line decoder with range sweep mode
// Revision: 1.0
// ============================================================================
`default_nettype none

module onehot_sweep_decoder
    import onehot_sweep_decoder_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_en,
    input  logic [IDX_W-1:0]      id_in,
    input  logic                  sweep_start,
    input  logic [IDX_W-1:0]      sweep_first,
    input  logic [IDX_W-1:0]      sweep_last,
    output logic                  ready,
    output logic [2**IDX_W-1:0]   one_hot_out,
    output logic [IDX_W-1:0]      idx_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  sweep_done
);

    localparam int OUT_W = 2**IDX_W;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W:0]     rem_q, rem_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   oh_q, oh_d;
    logic [IDX_W-1:0]   span;

    // span = N-1; modular subtraction handles wrapping ranges for free
    assign span = sweep_last - sweep_first;

    // rem_q counts sweep outputs still to be emitted after the current one
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        vld_d   = 1'b0;
        idx_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dec_en && sweep_start) begin
                    vld_d   = 1'b1;
                    idx_d   = id_in;
                    cur_d   = sweep_first;
                    rem_d   = {1'b0, span} + (IDX_W+1)'(1);
                    state_d = ST_PEND;
                end else if (dec_en) begin
                    vld_d = 1'b1;
                    idx_d = id_in;
                end else if (sweep_start) begin
                    vld_d   = 1'b1;
                    idx_d   = sweep_first;
                    cur_d   = sweep_first + IDX_W'(1);
                    rem_d   = {1'b0, span};
                    done_d  = (span == '0);
                    state_d = ST_SWEEP;
                end
            end
            ST_PEND, ST_SWEEP: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    vld_d   = 1'b1;
                    idx_d   = cur_q;
                    cur_d   = cur_q + IDX_W'(1);
                    rem_d   = rem_q - (IDX_W+1)'(1);
                    done_d  = (rem_q == (IDX_W+1)'(1));
                    state_d = ST_SWEEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    onehot_dec_n #(
        .IDX_W    (IDX_W)
    ) u_dec (
        .idx_i    (idx_d),
        .en_i     (vld_d),
        .onehot_o (oh_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            oh_q    <= oh_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = vld_q;
    assign idx_out     = idx_q;
    assign one_hot_out = oh_q;
    assign sweep_done  = done_q;

endmodule

`default_nettype wire
